mux_scan_ctrl: RTL
==================

// Module: mux_scan_ctrl
// PURPOSE
//   Scan sequencer placed directly upstream/around the 8:1 mux. Drives the mux select lines
//   over channels 0..7 and samples the single mux output bit after each settle interval.
//   Assembles the eight samples into one byte frame and reports it with a valid pulse.
//   Runs as a single-shot scan or as a continuous scan.
// PARAMETERS
//   SETTLE    1   cycles to wait after a sel change before sampling y_in; legal range 1..15
//   CNT_W     4   width of the settle counter; must satisfy 2**CNT_W > SETTLE
// PORTS
//   clk      in   1  single clock, all state updates on rising edge
//   rst      in   1  synchronous, active-high reset
//   start    in   1  begin a scan; sampled only in IDLE
//   mode     in   1  0 = single-shot, 1 = continuous; sampled at each frame end
//   y_in     in   1  mux output bit (mux y)
//   sel      out  3  mux select (mux sel[2:0]); sel[0] = pair, sel[1] = group, sel[2] = half
//   data     out  8  last completed frame; bit i = y_in sampled with sel == i
//   valid    out  1  one-cycle pulse: data updated this cycle
//   changed  out  1  one-cycle pulse, coincident with valid: new data != previous data
//   busy     out  1  high whenever state != IDLE
// BEHAVIOUR
//   Reset (rst high at edge): state = IDLE, sel = 0, cnt = 0, capture buffer = 0,
//     data = 0, valid = 0, changed = 0, busy = 0. Reset overrides everything.
//     Reset mid-scan discards the partial frame. No valid is produced for that frame.
//   States: IDLE, SETTLE, SAMPLE.
//   IDLE
//     sel is held at 0.
//     If start = 1 at the edge: go to SETTLE, sel = 0, cnt = 0.
//   SETTLE
//     cnt increments each edge.
//     When cnt == SETTLE-1: go to SAMPLE and clear cnt.
//     sel is stable throughout SETTLE and SAMPLE.
//   SAMPLE (one cycle)
//     The edge leaving SAMPLE writes y_in into buffer bit [sel].
//     If sel != 7: sel increments, next state is SETTLE.
//     If sel == 7 (frame end), at the same edge:
//       data = {y_in, buffer[6:0]}
//       valid = 1
//       changed = (new data != old data)
//     Then:
//       if mode = 1, sel = 0 and next state is SETTLE (back-to-back, no gap cycle);
//       else next state is IDLE.
//   Per-channel cost is SETTLE+1 cycles.
//     With start accepted at edge E, valid is high in the cycle after edge E + 8*(SETTLE+1).
//   valid and changed are high for exactly one cycle per frame; otherwise 0.
//   data holds its value between frames.
//   start while busy is ignored and is not queued. start during the valid cycle in
//     single-shot mode is accepted, because state is already IDLE.
//   busy falls at the same edge that valid rises (single-shot).
//     In continuous mode busy stays high.
//   mode changes mid-frame take effect only at frame end.
//   The first frame after reset compares against 0.
//   sel wraps 7 -> 0 only via frame end; it never exceeds 7.
// TESTING
//   T1: rst 3 cycles -> sel=0, data=0, valid=0, changed=0, busy=0.
//   T2: SETTLE=1, mode=0, mux in=8'hA5, start pulse at edge E ->
//         sel steps 0..7, each held 2 cycles;
//         valid=1 with data=8'hA5 and changed=1 in the cycle after E+16;
//         busy=0 after that edge.
//   T3: mode=1, in=8'h3C for frame 1, then 8'h3C, then 8'hC3 ->
//         valids exactly 16 cycles apart;
//         changed=1, then 0, then 1; data=3C, 3C, C3.
//   T4: start pulses while busy mid-frame -> no restart, sel sequence unbroken, exactly one valid.
//   T5: rst asserted while sel=4 -> next cycle IDLE, sel=0, data unchanged from reset value 0,
//         no valid; a fresh start then yields a full frame.
//   T6: SETTLE=3, in toggled only during SETTLE cycles and stable in SAMPLE ->
//         data matches the SAMPLE-cycle values; frame length 32 cycles.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for an 8:1 mux: steps sel over 0..7, samples y_in after a
// settle interval and reports the eight samples as one byte frame.
module mux_scan_ctrl #(
    parameter int SETTLE = 1,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       mode,
    input  logic       y_in,
    output logic [2:0] sel,
    output logic [7:0] data,
    output logic       valid,
    output logic       changed,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       cap;
    logic [7:0]       frame;

    // Channel 7 is taken straight from y_in so the frame lands on the same edge.
    assign frame = {y_in, cap[6:0]};
    assign busy  = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            sel     <= 3'd0;
            cnt     <= '0;
            cap     <= 8'h00;
            data    <= 8'h00;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            valid   <= 1'b0;
            changed <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    sel <= 3'd0;
                    cnt <= '0;
                    if (start) begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_SAMPLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    cap[sel] <= y_in;
                    if (sel != 3'd7) begin
                        sel   <= sel + 3'd1;
                        state <= S_SETTLE;
                    end else begin
                        data    <= frame;
                        valid   <= 1'b1;
                        changed <= (frame != data);
                        sel     <= 3'd0;
                        state   <= mode ? S_SETTLE : S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
